// File: rtl/count4_down_timer.sv
// rtl/count4_down_timer.sv - loadable down-counting timer with one-cycle terminal-count pulse
// Optional feature: define AUTO_RELOAD_EN to restart from the reload register after each terminal count.

module count4_down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] reload_reg;

  // Timer FSM: load > stop > start > enable, all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      tc         <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // tc is a pulse; only the edges that enter DONE raise it again
      tc <= 1'b0;
      if (load) begin
        count      <= load_val;
        reload_reg <= load_val;
        state      <= IDLE;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (count != '0) begin
                state <= RUN;
                busy  <= 1'b1;
              end else begin
                // a zero-length run still reports completion
                state <= DONE;
                tc    <= 1'b1;
              end
            end
          end
          RUN: begin
            if (stop) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (en) begin
              // treat anything at or below one as the final step so count cannot wrap
              if (count > WIDTH'(1)) begin
                count <= count - WIDTH'(1);
              end else begin
                count <= '0;
                tc    <= 1'b1;
                busy  <= 1'b0;
                state <= DONE;
              end
            end
          end
          DONE: begin
`ifdef AUTO_RELOAD_EN
            if (stop || (reload_reg == '0)) begin
              state <= IDLE;
            end else begin
              count <= reload_reg;
              state <= RUN;
              busy  <= 1'b1;
            end
`else
            state <= IDLE;
            count <= '0;
`endif
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count4_down_timer.sv
// tb/tb_count4_down_timer.sv - directed self-checking bench for count4_down_timer

module tb_count4_down_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       en = 1'b0;
  logic [3:0] count;
  logic       tc;
  logic       busy;

  int n_checks = 0;
  int n_fail = 0;

  count4_down_timer #(.WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .en       (en),
    .count    (count),
    .tc       (tc),
    .busy     (busy)
  );

  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect3(input string tag, input int c, input int t, input int b);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".tc"}, 32'(tc), 32'(t));
    check({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] v);
    load_val = v;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic en_seq [5];
  int   cnt_seq [5];

  initial begin
    // reset state
    #10;
    expect3("reset", 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    // load 5, run with en held
    do_load(4'd5);
    expect3("t2_load", 5, 0, 0);
    do_start();
    expect3("t2_start", 5, 0, 1);
    en = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      tick();
      expect3($sformatf("t2_cnt%0d", i), i, 0, 1);
    end
    tick();
    expect3("t2_tc", 0, 1, 0);
    tick();
`ifdef AUTO_RELOAD_EN
    expect3("t2_after", 5, 0, 1);
`else
    expect3("t2_after", 0, 0, 0);
`endif
    en = 1'b0;

    // gated enable
    do_load(4'd3);
    do_start();
    en_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    cnt_seq = '{2, 2, 1, 1, 0};
    for (int i = 0; i < 5; i++) begin
      en = en_seq[i];
      tick();
      expect3($sformatf("t3_step%0d", i), cnt_seq[i], (i == 4) ? 1 : 0, (i == 4) ? 0 : 1);
    end
    en = 1'b0;
    tick();
`ifdef AUTO_RELOAD_EN
    expect3("t3_after", 3, 0, 1);
`else
    expect3("t3_after", 0, 0, 0);
`endif

    // stop holds count, restart resumes
    do_load(4'd9);
    do_start();
    en = 1'b1;
    for (int i = 8; i >= 6; i--) begin
      tick();
      check($sformatf("t4_cnt%0d", i), 32'(count), 32'(i));
    end
    en = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    expect3("t4_stop", 6, 0, 0);
    en = 1'b1;
    tick();
    expect3("t4_idle_en", 6, 0, 0);
    en = 1'b0;
    do_start();
    expect3("t4_restart", 6, 0, 1);
    en = 1'b1;
    tick();
    expect3("t4_resume", 5, 0, 1);
    en = 1'b0;

    // zero-length run, load beats start
    do_load(4'd0);
    do_start();
    expect3("t5_zero_tc", 0, 1, 0);
    tick();
    expect3("t5_zero_after", 0, 0, 0);
    load_val = 4'd4;
    load = 1'b1;
    start = 1'b1;
    tick();
    load = 1'b0;
    start = 1'b0;
    expect3("t5_load_start", 4, 0, 0);
    en = 1'b1;
    tick();
    expect3("t5_still_idle", 4, 0, 0);
    en = 1'b0;

    // full-range run, no underflow
    do_load(4'd15);
    do_start();
    en = 1'b1;
    for (int i = 14; i >= 1; i--) begin
      tick();
      check($sformatf("t6_cnt%0d", i), 32'(count), 32'(i));
    end
    tick();
    expect3("t6_tc", 0, 1, 0);
    tick();
`ifdef AUTO_RELOAD_EN
    expect3("t6_reload", 15, 0, 1);
    tick();
    expect3("t6_reload_dec", 14, 0, 1);
`else
    expect3("t6_hold0", 0, 0, 0);
    tick();
    expect3("t6_no_wrap", 0, 0, 0);
`endif
    en = 1'b0;

`ifdef AUTO_RELOAD_EN
    // periodic terminal count every third cycle
    do_load(4'd2);
    do_start();
    en = 1'b1;
    cnt_seq = '{1, 0, 2, 1, 0};
    for (int i = 0; i < 5; i++) begin
      tick();
      expect3($sformatf("t7_per%0d", i), cnt_seq[i], (cnt_seq[i] == 0) ? 1 : 0, (cnt_seq[i] == 0) ? 0 : 1);
    end
    en = 1'b0;
`endif

    // stop during DONE ends in IDLE
    do_load(4'd2);
    do_start();
    en = 1'b1;
    tick();
    expect3("t8_cnt1", 1, 0, 1);
    tick();
    expect3("t8_tc", 0, 1, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    expect3("t8_stop_done", 0, 0, 0);
    tick();
    expect3("t8_stays_idle", 0, 0, 0);
    en = 1'b0;

    // asynchronous reset mid-run
    do_load(4'd9);
    do_start();
    en = 1'b1;
    tick();
    tick();
    expect3("t1_pre", 7, 0, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    expect3("t1_async", 0, 0, 0);
    tick();
    expect3("t1_held", 0, 0, 0);
    en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    expect3("t1_release", 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
